// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch unit for the single-cycle RISC-V core. Drives the fetch
// address to the instruction memory, captures the combinational instruction
// word that comes back, and queues {pc, instruction} pairs in a small prefetch
// FIFO. Decode drains the FIFO with a valid/ready handshake. A taken
// branch/jump redirects the fetch PC and flushes everything queued so far.
//
// Parameters
//   RESET_PC    PC loaded on reset (bits [1:0] must be zero)
//   FIFO_DEPTH  prefetch entries (power of two, >= 2)
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   reset            asynchronous, active-high reset
//   inst_Addr        fetch address to instruction memory (pure register output)
//   instruction      word returned by instruction memory for inst_Addr
//   fetch_en         1 allows new fetches, 0 freezes the fetch PC
//   redirect_valid   branch/jump taken this cycle (flushes and reloads PC)
//   redirect_target  new PC; bits [1:0] are ignored and forced to 00
//   out_valid        head entry available to decode
//   out_ready        decode accepts the head entry
//   out_instr        head instruction (0 when empty)
//   out_pc           head PC (0 when empty)
//   fifo_count       registered number of occupied entries
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [31:0]                   inst_Addr,
  input  logic [31:0]                   instruction,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_target,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  // One FIFO entry: the PC it was fetched from plus the returned word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  entry_t           mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake and per-cycle control
  // ---------------------------------------------------------------------------
  logic not_empty;
  logic full;
  logic pop;
  logic push;
  entry_t head;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == DEPTH_CNT);

  // Gated by redirect so decode never consumes an entry that is being flushed
  // in the same cycle.
  assign out_valid = not_empty & ~redirect_valid;
  assign pop       = out_valid & out_ready;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a
  // push when decode is draining it.
  assign push      = fetch_en & ~redirect_valid & (~full | pop);

  assign head      = mem_q[rd_ptr_q];
  assign out_pc    = not_empty ? head.pc    : 32'h0;
  assign out_instr = not_empty ? head.instr : 32'h0;

  assign inst_Addr  = fetch_pc_q;
  assign fifo_count = count_q;

  // The low target bits are architecturally ignored; fold them into a
  // deliberately unused net so the intent is explicit.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      // Redirect wins over everything: flush and reload the PC.
      fetch_pc_d = {redirect_target[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        // 32-bit add wraps naturally from FFFF_FFFC to 0000_0000.
        fetch_pc_d = fetch_pc_q + 32'd4;
        // Power-of-two depth: pointer overflow is the modulo wrap.
        wr_ptr_d   = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is not reset; count_q alone decides which entries
  // are meaningful, and the outputs are forced to zero while it is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: instruction};
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for inst_fetch_unit: directed vector table for the scenario
// sequences, a hand-written async-reset sequence, then randomized traffic
// checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   inst_Addr;
  logic [31:0]   instruction;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_target = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [CW-1:0] fifo_count;

  inst_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_Addr       (inst_Addr),
    .instruction     (instruction),
    .fetch_en        (fetch_en),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .fifo_count      (fifo_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model.
  assign instruction = 32'hA000_0000 | inst_Addr;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr, input int cnt,
                           input logic valid, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, " inst_Addr"},  inst_Addr,        addr);
    check({tag, " fifo_count"}, 32'(fifo_count),  32'(cnt));
    check({tag, " out_valid"},  32'(out_valid),   32'(valid));
    check({tag, " out_pc"},     out_pc,           pc);
    check({tag, " out_instr"},  out_instr,        instr);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Positioned 1 time unit after a rising edge: drive inputs for this cycle.
  task automatic drive(input logic fe, input logic rv, input logic [31:0] rt, input logic rdy);
    fetch_en        = fe;
    redirect_valid  = rv;
    redirect_target = rt;
    out_ready       = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    #2;
    check_all("reset", RPC, 0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          pre_reset;
    logic        fe, rv, rdy;
    logic [31:0] rt;
    logic [31:0] addr;
    int          cnt;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit pre, logic fe, logic rv, logic rdy, logic [31:0] rt,
                             logic [31:0] addr, int cnt, logic valid, logic [31:0] pc);
    vec_t r;
    r.pre_reset = pre; r.fe = fe; r.rv = rv; r.rdy = rdy; r.rt = rt;
    r.addr = addr; r.cnt = cnt; r.valid = valid; r.pc = pc;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: a queue of fetched entries plus the fetch PC.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  task automatic model_check(input string tag, input logic rv);
    logic [31:0] epc, ein;
    epc = (mq.size() != 0) ? mq[0].pc    : 32'h0;
    ein = (mq.size() != 0) ? mq[0].instr : 32'h0;
    check_all(tag, m_pc, mq.size(), (mq.size() != 0) && !rv, epc, ein);
  endtask

  task automatic model_step(input logic fe, input logic rv, input logic [31:0] rt, input logic rdy);
    bit do_pop, do_push;
    if (rv) begin
      mq.delete();
      m_pc = rt & 32'hFFFF_FFFC;
    end else begin
      do_pop  = (mq.size() != 0) && rdy;
      do_push = fe && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset then stream.
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0000, 0, 0, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0004, 1, 1, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0008, 1, 1, 32'h4));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_000C, 1, 1, 32'h8));
    // Backpressure fill from a fresh reset: six cycles with out_ready low.
    tbl.push_back(v(1, 1, 0, 0, 32'h0, 32'h0000_0000, 0, 0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0, 32'h0000_0004, 1, 1, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0, 32'h0000_0008, 2, 1, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0, 32'h0000_000C, 3, 1, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0, 32'h0000_0010, 4, 1, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0, 32'h0000_0010, 4, 1, 32'h0));
    // Full with simultaneous push/pop: count stays 4, address advances.
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0010, 4, 1, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0014, 4, 1, 32'h4));
    // Drain with fetch disabled, then hold at count 3.
    tbl.push_back(v(0, 0, 0, 1, 32'h0, 32'h0000_0018, 4, 1, 32'h8));
    tbl.push_back(v(0, 0, 0, 0, 32'h0, 32'h0000_0018, 3, 1, 32'hC));
    // Redirect flush to 0x103 with count 3: out_valid gated low.
    tbl.push_back(v(0, 1, 1, 1, 32'h0000_0103, 32'h0000_0018, 3, 0, 32'hC));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0100, 0, 0, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0104, 1, 1, 32'h0000_0100));
    // PC wrap via redirect to FFFF_FFF8.
    tbl.push_back(v(0, 1, 1, 1, 32'hFFFF_FFF8, 32'h0000_0108, 1, 0, 32'h0000_0104));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'hFFFF_FFF8, 0, 0, 32'h0));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFF8));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0000, 1, 1, 32'hFFFF_FFFC));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0004, 1, 1, 32'h0000_0000));
    tbl.push_back(v(0, 1, 0, 1, 32'h0, 32'h0000_0008, 1, 1, 32'h0000_0004));

    // Initial asynchronous reset, observed before any clock edge.
    #1;
    reset = 1'b1;
    #2;
    check_all("por", RPC, 0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].pre_reset) do_reset();
      drive(tbl[i].fe, tbl[i].rv, tbl[i].rt, tbl[i].rdy);
      #4;
      check_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].cnt, tbl[i].valid, tbl[i].pc,
                (tbl[i].cnt != 0) ? mem_word(tbl[i].pc) : 32'h0);
      @(posedge clk);
      #1;
    end

    // Async reset mid-stream: build count 2, then assert reset between edges.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    #4;
    check_all("arst_pre", 32'h0000_000C, 1, 1'b1, 32'h8, mem_word(32'h8));
    @(posedge clk);
    #1;
    check_all("arst_cnt2", 32'h0000_0010, 2, 1'b1, 32'h8, mem_word(32'h8));
    #2;
    reset = 1'b1;
    #1;
    check_all("arst_now", RPC, 0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic against the reference model.
    do_reset();
    mq.delete();
    m_pc = RPC;
    for (int n = 0; n < 600; n++) begin
      logic        fe, rv, rdy;
      logic [31:0] rt;
      fe  = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rt  = $urandom;
      if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      drive(fe, rv, rt, rdy);
      #4;
      model_check($sformatf("rnd%0d", n), rv);
      model_step(fe, rv, rt, rdy);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch unit for the single-cycle RISC-V core. It is the initiator side of the `inst_memory` interface: it drives `inst_Addr` and captures the combinational `instruction` return. The {pc, instruction} pairs go into a small prefetch FIFO. Decode drains the FIFO with a valid/ready handshake, and branch/jump resolution redirects the PC and flushes the FIFO.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Bits [1:0] must be 0.
- `FIFO_DEPTH`, default 4: prefetch entries. Must be a power of 2 and ≥ 2.
- `clk` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `inst_Addr` out 32: fetch address to `inst_memory`.
- `instruction` in 32: word from `inst_memory`. Combinational function of `inst_Addr`, valid in the same cycle.
- `fetch_en` in 1: 1 allows new fetches, 0 freezes the fetch PC. Draining continues.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_target` in 32: new PC. Bits [1:0] are ignored and forced to 00.
- `out_valid` out 1: head entry is available to decode.
- `out_ready` in 1: decode accepts the head entry.
- `out_instr` out 32: head instruction.
- `out_pc` out 32: head PC.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupied entries.

## Operation
- State: `fetch_pc` (32-bit register), FIFO storage of FIFO_DEPTH × 64 bits, read/write pointers, and a count.
- `inst_Addr` = `fetch_pc` at all times. It is a direct register output with no combinational path from inputs.
- Define these per-cycle signals:
  - pop = `out_valid` & `out_ready`
  - push = `fetch_en` & !`redirect_valid` & (count < FIFO_DEPTH | pop)
- On push: write {`fetch_pc`, `instruction`} at the write pointer, then `fetch_pc` ← `fetch_pc` + 4. The add is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- On pop: advance the read pointer.
- Count update: count + push − pop. Push and pop together leave count unchanged, including when the FIFO is full.
- Pointers wrap modulo FIFO_DEPTH.
- Redirect (`redirect_valid`=1) has priority over everything else:
  - FIFO is flushed: count ← 0 and both pointers ← 0.
  - `fetch_pc` ← {`redirect_target`[31:2], 2'b00}.
  - No push occurs, regardless of `fetch_en`.
  - A pop cannot occur, because `out_valid` is forced low (see below).
- `out_valid` = (count ≠ 0) & !`redirect_valid`. This is combinational gating so that decode never consumes a stale entry in the redirect cycle.
- `out_instr` / `out_pc` show the head entry when count ≠ 0, and 32'h0 when count = 0.
- `fetch_en`=0: `fetch_pc` holds and there is no push. Pops proceed normally.
- Stall (`out_ready`=0, FIFO full): no push, `fetch_pc` holds, and `inst_Addr` stays stable.

## Timing
- Reset values (asserted asynchronously, effective immediately):
  - `inst_Addr` = RESET_PC
  - `fifo_count` = 0
  - `out_valid` = 0
  - `out_instr` = 0
  - `out_pc` = 0
- Reset asserted mid-operation discards all FIFO contents and any redirect in flight.
- After reset deasserts, the first push happens at the first rising edge with `fetch_en`=1.
- Fetch-to-decode latency is 1 cycle: a word fetched at cycle N is `out_valid` in cycle N+1.
- Throughput is 1 instruction per cycle when `out_ready`=1 and `fetch_en`=1. The FIFO then sits at count 1.
- Redirect asserted in cycle N:
  - `inst_Addr` = target in cycle N+1.
  - First target instruction reaches `out_valid` in cycle N+2.
  - Two bubbles.
- When the FIFO is full, a pop in cycle N permits a push in the same cycle N.
- `fifo_count` is registered and reflects state after the last edge.

## Test plan
- Setup for all scenarios: the memory model returns `instruction` = 32'hA000_0000 | `inst_Addr`.
- Reset then stream: release `reset` with `fetch_en`=1 and `out_ready`=1 → `inst_Addr` sequence 0, 4, 8, 12. Decode receives (pc=0, instr=A000_0000), then (4, A000_0004), … one per cycle starting 1 cycle after the first edge.
- Backpressure fill: `out_ready`=0 for 6 cycles →
  - `fifo_count` climbs to 4 and `inst_Addr` freezes at 16.
  - Raising `out_ready` drains pcs 0, 4, 8, 12, then 16, 20, … with no gap or duplicate.
- Full plus simultaneous push/pop: at count=4, hold `out_ready`=1 for one cycle → count stays 4, one entry retires, and `inst_Addr` advances by 4.
- Redirect flush:
  - Setup: count=3, then `redirect_valid`=1 with target 32'h0000_0103.
  - In that cycle, `out_valid`=0.
  - Next cycle: `fifo_count`=0 and `inst_Addr`=32'h0000_0100.
  - The cycle after, `out_pc`=0x100 and `out_instr`=A000_0100.
- PC wrap: redirect to 32'hFFFF_FFF8 → decode sees pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset mid-stream: assert `reset` between clock edges with count=2 → `out_valid`=0, `fifo_count`=0 and `inst_Addr`=RESET_PC immediately, without waiting for a clock edge.
